// File: rtl/wm_pkg.sv
// Shared definitions for the multi-cycle washing-machine sequencer:
// phase encodings, phase width and the prescaler divide helper.
package wm_pkg;

    localparam int PHASE_W = 3;

    typedef enum logic [PHASE_W-1:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        WASH  = 3'd2,
        RINSE = 3'd3,
        SPIN  = 3'd4,
        DRAIN = 3'd5
    } state_t;

    // Clock cycles per tick for a given prescale select.
    function automatic int unsigned div_value(input int unsigned base_div,
                                              input logic [1:0]  div_sel);
        return base_div << div_sel;
    endfunction

endpackage

// File: rtl/wm_tick_gen.sv
// Prescaler for the washing-machine sequencer: one-cycle tick every
// (BASE_DIV << div_sel) enabled cycles, restartable through clr.
module wm_tick_gen
    import wm_pkg::*;
#(
    parameter int unsigned BASE_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [1:0] div_sel,
    output logic       tick
);

    localparam int DIV_W = $clog2(BASE_DIV * 8 + 1);

    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] terminal;

    assign terminal = DIV_W'(div_value(BASE_DIV, div_sel) - 1);
    assign tick     = en && (count == terminal);

    // clr wins over en so every phase starts from a fresh tick period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == terminal) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/wm_ctrl_multi.sv
// Washing-machine sequencer IDLE -> FILL -> (WASH -> RINSE) x N -> SPIN -> IDLE
// with pause and abort. Define WM_DRAIN_PHASE_EN to add a DRAIN phase.
module wm_ctrl_multi
    import wm_pkg::*;
#(
    parameter int BASE_DIV    = 1000,
    parameter int FILL_TICKS  = 2,
    parameter int WASH_TICKS  = 5,
    parameter int RINSE_TICKS = 2,
    parameter int SPIN_TICKS  = 1,
    parameter int MAX_CYCLES  = 4,
    parameter int CNT_W       = 16
`ifdef WM_DRAIN_PHASE_EN
    ,
    parameter int DRAIN_TICKS = 1
`endif
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic [1:0]                                         clk_freq,
    input  logic                                               coin_in,
    input  logic [$clog2(MAX_CYCLES+1)-1:0]                    wash_cycles,
    input  logic                                               timer_pause,
    input  logic                                               abort,
    output logic [PHASE_W-1:0]                                 phase,
    output logic                                               wash_done,
    output logic                                               busy,
    output logic                                               paused,
    output logic                                               done_pulse,
    output logic [((MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1)-1:0] cycle_idx
);

    localparam int WC_W  = $clog2(MAX_CYCLES + 1);
    localparam int IDX_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] phase_cnt;
    logic [CNT_W-1:0] phase_len;
    logic [WC_W-1:0]  target;
    logic [1:0]       div_sel;
    logic             tick;
    logic             phase_last;
    logic             abort_ok;
    logic             more_cycles;
    logic             tick_clr;
    logic             tick_en;
`ifdef WM_DRAIN_PHASE_EN
    logic             drain_abort;
`endif

    assign phase     = state;
    assign wash_done = (state == IDLE);
    assign busy      = (state != IDLE);

    assign tick_en  = (state != IDLE) && !timer_pause;
    assign tick_clr = (state == IDLE) || (state_next != state);

    wm_tick_gen #(
        .BASE_DIV (BASE_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .clr     (tick_clr),
        .en      (tick_en),
        .div_sel (div_sel),
        .tick    (tick)
    );

    always_comb begin
        phase_len = CNT_W'(1);
        case (state)
            FILL:    phase_len = CNT_W'(FILL_TICKS);
            WASH:    phase_len = CNT_W'(WASH_TICKS);
            RINSE:   phase_len = CNT_W'(RINSE_TICKS);
            SPIN:    phase_len = CNT_W'(SPIN_TICKS);
`ifdef WM_DRAIN_PHASE_EN
            DRAIN:   phase_len = CNT_W'(DRAIN_TICKS);
`endif
            default: phase_len = CNT_W'(1);
        endcase
    end

    assign phase_last  = tick && (phase_cnt == phase_len - CNT_W'(1));
    assign more_cycles = (32'(cycle_idx) + 32'd1) < 32'(target);

`ifdef WM_DRAIN_PHASE_EN
    // A drain already in progress must finish even if abort is held.
    assign abort_ok = abort && (state != IDLE) && (state != DRAIN);
`else
    assign abort_ok = abort && (state != IDLE);
`endif

    // Priority in active phases: abort, then pause, then phase-end tick.
    always_comb begin
        state_next = state;
        if (state == IDLE) begin
            if (coin_in) state_next = FILL;
        end else if (abort_ok) begin
`ifdef WM_DRAIN_PHASE_EN
            state_next = (state == SPIN) ? IDLE : DRAIN;
`else
            state_next = IDLE;
`endif
        end else if (!timer_pause && phase_last) begin
            case (state)
                FILL:    state_next = WASH;
                WASH:    state_next = RINSE;
`ifdef WM_DRAIN_PHASE_EN
                RINSE:   state_next = more_cycles ? WASH : DRAIN;
                DRAIN:   state_next = drain_abort ? IDLE : SPIN;
`else
                RINSE:   state_next = more_cycles ? WASH : SPIN;
`endif
                SPIN:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Phase counter restarts on every phase entry, like the prescaler.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_cnt <= '0;
        end else if (tick_clr) begin
            phase_cnt <= '0;
        end else if (tick) begin
            phase_cnt <= phase_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_idx <= '0;
        end else if (state_next == IDLE || abort_ok) begin
            cycle_idx <= '0;
        end else if (state == RINSE && state_next == WASH) begin
            cycle_idx <= cycle_idx + IDX_W'(1);
        end
    end

    // Program settings are frozen at the coin edge for the whole run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            target  <= '0;
            div_sel <= '0;
        end else if (state == IDLE && coin_in) begin
            div_sel <= clk_freq;
            if (wash_cycles == '0)
                target <= WC_W'(1);
            else if (32'(wash_cycles) > 32'(MAX_CYCLES))
                target <= WC_W'(MAX_CYCLES);
            else
                target <= wash_cycles;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_pulse <= 1'b0;
            paused     <= 1'b0;
        end else begin
            done_pulse <= (state == SPIN) && (state_next == IDLE) && !abort_ok;
            paused     <= (state != IDLE) && (state_next != IDLE) && timer_pause;
        end
    end

`ifdef WM_DRAIN_PHASE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drain_abort <= 1'b0;
        end else if (state_next == IDLE) begin
            drain_abort <= 1'b0;
        end else if (abort_ok && state != SPIN) begin
            drain_abort <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_wm_ctrl_multi.sv
// Directed self-checking bench for wm_ctrl_multi (BASE_DIV=2, FILL=2,
// WASH=3, RINSE=2, SPIN=1, MAX_CYCLES=4); honours WM_DRAIN_PHASE_EN.
module tb_wm_ctrl_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] clk_freq;
    logic       coin_in;
    logic [2:0] wash_cycles;
    logic       timer_pause;
    logic       abort;
    logic [2:0] phase;
    logic       wash_done;
    logic       busy;
    logic       paused;
    logic       done_pulse;
    logic [1:0] cycle_idx;

    int compared   = 0;
    int mismatched = 0;

    int          cfg_pause_at  = 0;
    int          cfg_pause_len = 0;
    int          cfg_abort_at  = 0;
    int          cfg_change_at = 0;

    int          r_total;
    int          r_first;
    int          r_pcnt;
    logic [63:0] r_seq;
    logic [63:0] r_idx;
    logic        r_early;
    logic        r_end_pulse;
    logic        r_end_done;

    wm_ctrl_multi #(
        .BASE_DIV    (2),
        .FILL_TICKS  (2),
        .WASH_TICKS  (3),
        .RINSE_TICKS (2),
        .SPIN_TICKS  (1),
        .MAX_CYCLES  (4),
        .CNT_W       (16)
`ifdef WM_DRAIN_PHASE_EN
        ,
        .DRAIN_TICKS (1)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_freq    (clk_freq),
        .coin_in     (coin_in),
        .wash_cycles (wash_cycles),
        .timer_pause (timer_pause),
        .abort       (abort),
        .phase       (phase),
        .wash_done   (wash_done),
        .busy        (busy),
        .paused      (paused),
        .done_pulse  (done_pulse),
        .cycle_idx   (cycle_idx)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_triggers(input int n);
        if (cfg_pause_at != 0 && n == cfg_pause_at) timer_pause = 1'b1;
        if (cfg_pause_at != 0 && n == cfg_pause_at + cfg_pause_len) timer_pause = 1'b0;
        if (cfg_abort_at != 0 && n == cfg_abort_at) abort = 1'b1;
        if (cfg_abort_at != 0 && n == cfg_abort_at + 1) abort = 1'b0;
        if (cfg_change_at != 0 && n == cfg_change_at) begin
            clk_freq    = 2'd3;
            wash_cycles = 3'd4;
        end
    endtask

    task automatic start_program(input logic [2:0] wc, input logic [1:0] f, input bit keep);
        coin_in     = 1'b1;
        wash_cycles = wc;
        clk_freq    = f;
        step();
        if (!keep) coin_in = 1'b0;
    endtask

    // Follows a program from its first FILL cycle back to IDLE, recording
    // the phase sequence, cycle_idx per phase, and busy-cycle count.
    task automatic run_to_idle();
        int         n;
        logic [2:0] cur;
        bit         first;
        n       = 1;
        cur     = phase;
        first   = 1'b1;
        r_seq   = 64'(phase);
        r_idx   = 64'(cycle_idx);
        r_first = 1;
        r_pcnt  = 0;
        r_early = done_pulse;
        do_triggers(1);
        while (busy && n < 2000) begin
            step();
            if (busy) begin
                n++;
                if (phase != cur) begin
                    cur   = phase;
                    first = 1'b0;
                    r_seq = {r_seq[59:0], 1'b0, phase};
                    r_idx = {r_idx[59:0], 2'b00, cycle_idx};
                end else if (first) begin
                    r_first++;
                end
                if (paused && phase == 3'd2) r_pcnt++;
                if (done_pulse) r_early = 1'b1;
                do_triggers(n);
            end
        end
        r_total       = busy ? -1 : n;
        r_end_pulse   = done_pulse;
        r_end_done    = wash_done;
        timer_pause   = 1'b0;
        abort         = 1'b0;
        cfg_pause_at  = 0;
        cfg_pause_len = 0;
        cfg_abort_at  = 0;
        cfg_change_at = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clk_freq = 2'd0; coin_in = 1'b0; wash_cycles = 3'd0;
        timer_pause = 1'b0; abort = 1'b0;
        #23;
        compared++;
        if ({phase, wash_done, busy, paused, done_pulse, cycle_idx} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0}) begin
            mismatched++;
            $display("[TB] FAIL reset_hold: got %b expected %b", {phase, wash_done, busy, paused, done_pulse, cycle_idx}, 9'b000_1000_00);
        end
        @(negedge clk);
        rst = 1'b1;
        step();
        compared++;
        if ({phase, wash_done, busy, paused, done_pulse, cycle_idx} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0}) begin
            mismatched++;
            $display("[TB] FAIL reset_release: got %b expected %b", {phase, wash_done, busy, paused, done_pulse, cycle_idx}, 9'b000_1000_00);
        end
    endtask

    task automatic test_single();
        start_program(3'd1, 2'd0, 1'b0);
        run_to_idle();
        compared++;
        if (r_first !== 4) begin mismatched++; $display("[TB] FAIL single_fill_len: got %0d expected 4", r_first); end
        compared++;
        if (r_total !== 16) begin mismatched++; $display("[TB] FAIL single_total: got %0d expected 16", r_total); end
        compared++;
        if (r_seq !== 64'h1234) begin mismatched++; $display("[TB] FAIL single_seq: got %0h expected 1234", r_seq); end
        compared++;
        if ({r_early, r_end_pulse, r_end_done} !== 3'b011) begin
            mismatched++; $display("[TB] FAIL single_done: got %b expected 011", {r_early, r_end_pulse, r_end_done});
        end
        step();
        compared++;
        if ({done_pulse, wash_done} !== 2'b01) begin
            mismatched++; $display("[TB] FAIL single_pulse_width: got %b expected 01", {done_pulse, wash_done});
        end
    endtask

    task automatic test_double();
        start_program(3'd2, 2'd0, 1'b0);
        run_to_idle();
        compared++;
        if (r_seq !== 64'h123234) begin mismatched++; $display("[TB] FAIL double_seq: got %0h expected 123234", r_seq); end
        compared++;
        if (r_idx !== 64'h000111) begin mismatched++; $display("[TB] FAIL double_idx: got %0h expected 000111", r_idx); end
        compared++;
        if (r_total !== 26) begin mismatched++; $display("[TB] FAIL double_total: got %0d expected 26", r_total); end
        compared++;
        if (r_end_pulse !== 1'b1) begin mismatched++; $display("[TB] FAIL double_pulse: got %b expected 1", r_end_pulse); end
    endtask

    task automatic test_prescale();
        cfg_change_at = 3;
        start_program(3'd1, 2'd1, 1'b0);
        run_to_idle();
        compared++;
        if (r_total !== 32) begin mismatched++; $display("[TB] FAIL prescale_total: got %0d expected 32", r_total); end
        compared++;
        if (r_seq !== 64'h1234) begin mismatched++; $display("[TB] FAIL prescale_seq: got %0h expected 1234", r_seq); end
        compared++;
        if (r_first !== 8) begin mismatched++; $display("[TB] FAIL prescale_fill_len: got %0d expected 8", r_first); end
    endtask

    task automatic test_pause();
        cfg_pause_at  = 6;
        cfg_pause_len = 5;
        start_program(3'd1, 2'd0, 1'b0);
        run_to_idle();
        compared++;
        if (r_pcnt !== 5) begin mismatched++; $display("[TB] FAIL pause_cycles: got %0d expected 5", r_pcnt); end
        compared++;
        if (r_total !== 21) begin mismatched++; $display("[TB] FAIL pause_total: got %0d expected 21", r_total); end
        compared++;
        if (r_seq !== 64'h1234) begin mismatched++; $display("[TB] FAIL pause_seq: got %0h expected 1234", r_seq); end
        timer_pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            compared++;
            if ({phase, paused, busy} !== 5'b000_0_0) begin
                mismatched++; $display("[TB] FAIL pause_idle: got %b expected 00000", {phase, paused, busy});
            end
        end
        timer_pause = 1'b0;
    endtask

    task automatic test_abort();
        cfg_abort_at = 12;
        start_program(3'd1, 2'd0, 1'b0);
        run_to_idle();
`ifdef WM_DRAIN_PHASE_EN
        compared++;
        if (r_total !== 14) begin mismatched++; $display("[TB] FAIL abort_total: got %0d expected 14", r_total); end
        compared++;
        if (r_seq !== 64'h1235) begin mismatched++; $display("[TB] FAIL abort_seq: got %0h expected 1235", r_seq); end
`else
        compared++;
        if (r_total !== 12) begin mismatched++; $display("[TB] FAIL abort_total: got %0d expected 12", r_total); end
        compared++;
        if (r_seq !== 64'h123) begin mismatched++; $display("[TB] FAIL abort_seq: got %0h expected 123", r_seq); end
`endif
        compared++;
        if ({r_early, r_end_pulse, r_end_done} !== 3'b001) begin
            mismatched++; $display("[TB] FAIL abort_done: got %b expected 001", {r_early, r_end_pulse, r_end_done});
        end
    endtask

    task automatic test_clamp();
        start_program(3'd0, 2'd0, 1'b0);
        run_to_idle();
        compared++;
        if (r_total !== 16) begin mismatched++; $display("[TB] FAIL clamp0_total: got %0d expected 16", r_total); end
        compared++;
        if (r_seq !== 64'h1234) begin mismatched++; $display("[TB] FAIL clamp0_seq: got %0h expected 1234", r_seq); end
        start_program(3'd7, 2'd0, 1'b0);
        run_to_idle();
        compared++;
        if (r_total !== 46) begin mismatched++; $display("[TB] FAIL clamp7_total: got %0d expected 46", r_total); end
        compared++;
        if (r_seq !== 64'h1232323234) begin mismatched++; $display("[TB] FAIL clamp7_seq: got %0h expected 1232323234", r_seq); end
        compared++;
        if (r_idx !== 64'h0001122333) begin mismatched++; $display("[TB] FAIL clamp7_idx: got %0h expected 0001122333", r_idx); end
    endtask

    task automatic test_reset_mid();
        start_program(3'd2, 2'd0, 1'b0);
        for (int i = 0; i < 15; i++) step();
        compared++;
        if ({phase, cycle_idx} !== {3'd2, 2'd1}) begin
            mismatched++; $display("[TB] FAIL midrun_state: got %b expected 01001", {phase, cycle_idx});
        end
        #2 rst = 1'b0;
        #1;
        compared++;
        if ({phase, wash_done, busy, paused, done_pulse, cycle_idx} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0}) begin
            mismatched++;
            $display("[TB] FAIL reset_mid: got %b expected %b", {phase, wash_done, busy, paused, done_pulse, cycle_idx}, 9'b000_1000_00);
        end
        @(negedge clk);
        rst = 1'b1;
        step();
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mid_idle: got %b expected 0", busy); end
        start_program(3'd1, 2'd0, 1'b0);
        run_to_idle();
        compared++;
        if (r_total !== 16) begin mismatched++; $display("[TB] FAIL reset_mid_rerun: got %0d expected 16", r_total); end
    endtask

    task automatic test_back_to_back();
        int waited;
        start_program(3'd1, 2'd0, 1'b1);
        run_to_idle();
        compared++;
        if (r_total !== 16) begin mismatched++; $display("[TB] FAIL coin_held_total: got %0d expected 16", r_total); end
        step();
        compared++;
        if (phase !== 3'd1) begin mismatched++; $display("[TB] FAIL back_to_back_restart: got %0d expected 1", phase); end
        coin_in = 1'b0;
        abort   = 1'b1;
        step();
        abort   = 1'b0;
        waited  = 0;
        while (busy && waited < 20) begin
            compared++;
            if (done_pulse !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_fill_pulse: got %b expected 0", done_pulse); end
            step();
            waited++;
        end
`ifdef WM_DRAIN_PHASE_EN
        compared++;
        if (waited !== 2) begin mismatched++; $display("[TB] FAIL abort_fill_drain: got %0d expected 2", waited); end
`else
        compared++;
        if (waited !== 0) begin mismatched++; $display("[TB] FAIL abort_fill_idle: got %0d expected 0", waited); end
`endif
        compared++;
        if ({busy, done_pulse} !== 2'b00) begin mismatched++; $display("[TB] FAIL abort_fill_end: got %b expected 00", {busy, done_pulse}); end
    endtask

    initial begin
        $display("[TB] wm_ctrl_multi directed bench");
        test_reset();
        test_single();
        test_double();
        test_prescale();
        test_pause();
        test_abort();
        test_clamp();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
